window_stream_feeder: RTL and testbench

Upstream neighbour of the spatial convolution core; one instance per input channel. It accepts a raster-order pixel stream for one channel and builds a KERNEL_SIZE x KERNEL_SIZE sliding window through an internal line buffer. Each window at a valid stride position is presented to the core as window_o / window_valid_o. The current window is frozen and the input stream stalled until the core completes its hold_window handshake.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/pixel_line_buffer.sv | 43 ++++
 rtl/window_stream_feeder.sv | 147 ++++++++++++++
 tb/tb_window_stream_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution front end.
package conv_pkg;

  // Window feeder handshake states.
  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    HELD    = 2'd2
  } feeder_state_t;

  // Entries needed so the oldest pixel of a K x K window is still held when
  // its bottom-right pixel arrives.
  function automatic int line_buf_depth(input int k, input int n_cols);
    return (k - 1) * n_cols + k;
  endfunction

  // Number of stride-aligned windows a full frame produces.
  function automatic int windows_per_frame(input int n_rows, input int n_cols,
                                           input int k, input int s);
    return ((n_rows - k) / s + 1) * ((n_cols - k) / s + 1);
  endfunction

endpackage

// File: rtl/pixel_line_buffer.sv
// Enable-gated pixel shift register with synchronous clear and K*K window taps.
// Entry 0 holds the newest pixel; tap 0 is the top-left of the window.
module pixel_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N_COLS      = 28,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic [DATA_WIDTH-1:0] taps [0:KERNEL_SIZE*KERNEL_SIZE-1]
);

  localparam int K     = KERNEL_SIZE;
  localparam int DEPTH = line_buf_depth(KERNEL_SIZE, N_COLS);

  logic [DATA_WIDTH-1:0] line_reg [0:DEPTH-1];

  // Shift one position per accepted pixel; clear wipes stale frame data.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_reg[i] <= '0;
      end
    end else if (shift) begin
      line_reg[0] <= pixel;
      for (int i = 1; i < DEPTH; i++) begin
        line_reg[i] <= line_reg[i-1];
      end
    end
  end

  // Row r of the window sits (K-1-r) lines back, column c sits (K-1-c) pixels back.
  for (genvar gi = 0; gi < K * K; gi++) begin : g_tap
    localparam int R = gi / K;
    localparam int C = gi % K;
    assign taps[gi] = line_reg[(K - 1 - R) * N_COLS + (K - 1 - C)];
  end

endmodule

// File: rtl/window_stream_feeder.sv
// Builds a sliding K x K window from a raster pixel stream and presents each
// stride-aligned window to the convolution core, stalling input until the core
// has raised and dropped hold_window_i.
module window_stream_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N_ROWS      = 28,
  parameter int N_COLS      = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int CONV_STRIDE = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] pixel_i,
  input  logic                  pixel_valid_i,
  output logic                  pixel_ready_o,
  input  logic                  hold_window_i,
  output logic [DATA_WIDTH-1:0] window_o [0:KERNEL_SIZE*KERNEL_SIZE-1],
  output logic                  window_valid_o,
  output logic                  frame_done_o
);

  localparam int K         = KERNEL_SIZE;
  localparam int ROW_W     = $clog2(N_ROWS) + 1;
  localparam int COL_W     = $clog2(N_COLS) + 1;
  localparam int PH_W      = $clog2(CONV_STRIDE) + 1;
  localparam int WIN_TOTAL = windows_per_frame(N_ROWS, N_COLS, K, CONV_STRIDE);
  localparam int WIN_W     = $clog2(WIN_TOTAL) + 1;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [COL_W-1:0] COL_EDGE = COL_W'(K - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CONV_STRIDE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_TOTAL - 1);

  feeder_state_t    state_reg, state_next;
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic [PH_W-1:0]  row_phase_reg;
  logic [PH_W-1:0]  col_phase_reg;
  logic [WIN_W-1:0] win_count_reg;
  logic             last_window_reg;
  logic             transfer;
  logic             window_pos;

  // Acceptance is decided by state alone so the handshake has no comb loop.
  assign transfer = pixel_valid_i && (state_reg == FILL);

  // Phase counters stay at zero through the border and count stride steps after
  // it, so phase zero past the border marks a stride-aligned window corner.
  assign window_pos = (col_reg >= COL_EDGE) && (row_reg >= ROW_EDGE) &&
                      (col_phase_reg == '0) && (row_phase_reg == '0);

  pixel_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_COLS     (N_COLS),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_line_buffer (
    .clock(clock_i),
    .clear(!reset_i),
    .shift(transfer),
    .pixel(pixel_i),
    .taps (window_o)
  );

  // State register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs; frame_done fires on the final retire.
  always_comb begin
    state_next     = state_reg;
    pixel_ready_o  = 1'b0;
    window_valid_o = 1'b0;
    frame_done_o   = 1'b0;
    case (state_reg)
      FILL: begin
        pixel_ready_o = 1'b1;
        if (pixel_valid_i && window_pos) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        window_valid_o = 1'b1;
        if (hold_window_i) begin
          state_next = HELD;
        end
      end
      HELD: begin
        window_valid_o = 1'b1;
        if (!hold_window_i) begin
          state_next   = FILL;
          frame_done_o = last_window_reg;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Raster position, stride phase and per-frame window tally, advanced per transfer.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      row_reg         <= '0;
      col_reg         <= '0;
      row_phase_reg   <= '0;
      col_phase_reg   <= '0;
      win_count_reg   <= '0;
      last_window_reg <= 1'b0;
    end else if (transfer) begin
      if (col_reg == COL_LAST) begin
        col_reg       <= '0;
        col_phase_reg <= '0;
        if (row_reg == ROW_LAST) begin
          row_reg       <= '0;
          row_phase_reg <= '0;
        end else begin
          row_reg <= row_reg + 1'b1;
          if (row_reg >= ROW_EDGE) begin
            row_phase_reg <= (row_phase_reg == PH_LAST) ? '0 : row_phase_reg + 1'b1;
          end
        end
      end else begin
        col_reg <= col_reg + 1'b1;
        if (col_reg >= COL_EDGE) begin
          col_phase_reg <= (col_phase_reg == PH_LAST) ? '0 : col_phase_reg + 1'b1;
        end
      end
      if (window_pos) begin
        if (win_count_reg == WIN_LAST) begin
          win_count_reg   <= '0;
          last_window_reg <= 1'b1;
        end else begin
          win_count_reg   <= win_count_reg + 1'b1;
          last_window_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_stream_feeder.sv
// Directed bench: a 5x5 frame, 3x3 kernel, stride 1 (dut_a) and stride 2 (dut_b).
module tb_window_stream_feeder;

  localparam int DW = 32;
  localparam int NC = 5;
  localparam int K  = 3;
  localparam int KK = K * K;
  localparam int WB = DW * KK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] pixel_a = '0, pixel_b = '0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  logic hold_a, hold_b;
  logic ready_a, ready_b, wv_a, wv_b, fd_a, fd_b;
  logic [DW-1:0] win_a [0:KK-1];
  logic [DW-1:0] win_b [0:KK-1];
  logic [WB-1:0] wflat_a, wflat_b;

  int comps = 0;
  int errs  = 0;

  int hold_len_a = 3, hold_len_b = 3;
  bit hold_rand_a = 1'b0;

  // Monitor bookkeeping, written only by the monitor process.
  logic [WB-1:0] cap_q0[$];
  logic [WB-1:0] cap_q1[$];
  int rq0[$];
  int xq0[$];
  int xfer_cnt [2] = '{0, 0};
  int fd_cnt   [2] = '{0, 0};
  int fd_at    [2] = '{0, 0};
  int stab_err [2] = '{0, 0};
  int run_len  [2] = '{0, 0};
  int last_run [2] = '{0, 0};
  logic prev_wv [2] = '{1'b0, 1'b0};
  logic [WB-1:0] cur_w [2];

  always #5 clk = ~clk;

  window_stream_feeder #(
    .DATA_WIDTH(DW), .N_ROWS(5), .N_COLS(5), .KERNEL_SIZE(K), .CONV_STRIDE(1)
  ) dut_a (
    .clock_i(clk), .reset_i(rst_n), .pixel_i(pixel_a), .pixel_valid_i(pv_a),
    .pixel_ready_o(ready_a), .hold_window_i(hold_a), .window_o(win_a),
    .window_valid_o(wv_a), .frame_done_o(fd_a)
  );

  window_stream_feeder #(
    .DATA_WIDTH(DW), .N_ROWS(5), .N_COLS(5), .KERNEL_SIZE(K), .CONV_STRIDE(2)
  ) dut_b (
    .clock_i(clk), .reset_i(rst_n), .pixel_i(pixel_b), .pixel_valid_i(pv_b),
    .pixel_ready_o(ready_b), .hold_window_i(hold_b), .window_o(win_b),
    .window_valid_o(wv_b), .frame_done_o(fd_b)
  );

  for (genvar gi = 0; gi < KK; gi++) begin : g_flat
    assign wflat_a[gi*DW +: DW] = win_a[gi];
    assign wflat_b[gi*DW +: DW] = win_b[gi];
  end

  // Consumer for dut_a: raise hold one cycle after valid, drop it N cycles later.
  initial begin
    int n;
    hold_a = 1'b0;
    forever begin
      @(negedge clk);
      if (wv_a === 1'b1 && !hold_a) begin
        @(posedge clk); #1;
        hold_a = 1'b1;
        n = hold_rand_a ? int'($urandom_range(6, 1)) : hold_len_a;
        repeat (n) @(posedge clk);
        #1;
        hold_a = 1'b0;
        @(posedge clk);
      end
    end
  end

  // Consumer for dut_b, fixed hold length.
  initial begin
    hold_b = 1'b0;
    forever begin
      @(negedge clk);
      if (wv_b === 1'b1 && !hold_b) begin
        @(posedge clk); #1;
        hold_b = 1'b1;
        repeat (hold_len_b) @(posedge clk);
        #1;
        hold_b = 1'b0;
        @(posedge clk);
      end
    end
  end

  // Monitor: capture windows at valid rise, track stability, transfers, frame_done.
  always @(negedge clk) begin
    logic [WB-1:0] w [2];
    logic v [2], r [2], p [2], f [2];
    w[0] = wflat_a; w[1] = wflat_b;
    v[0] = wv_a;    v[1] = wv_b;
    r[0] = ready_a; r[1] = ready_b;
    p[0] = pv_a;    p[1] = pv_b;
    f[0] = fd_a;    f[1] = fd_b;
    for (int k = 0; k < 2; k++) begin
      if (v[k] === 1'b1 && prev_wv[k] !== 1'b1) begin
        if (k == 0) begin
          cap_q0.push_back(w[k]);
          rq0.push_back(xfer_cnt[k]);
        end else begin
          cap_q1.push_back(w[k]);
        end
        run_len[k] = 0;
      end
      if (v[k] === 1'b1 && prev_wv[k] === 1'b1 && w[k] !== cur_w[k]) stab_err[k]++;
      if (v[k] === 1'b1 && r[k] !== 1'b0) stab_err[k]++;
      if (v[k] === 1'b1) run_len[k]++;
      if (v[k] !== 1'b1 && prev_wv[k] === 1'b1) last_run[k] = run_len[k];
      if (f[k] === 1'b1) begin
        fd_cnt[k]++;
        fd_at[k] = (k == 0) ? cap_q0.size() : cap_q1.size();
      end
      if (p[k] === 1'b1 && r[k] === 1'b1) begin
        xfer_cnt[k]++;
        if (k == 0) xq0.push_back(int'(pixel_a));
      end
      cur_w[k]   = w[k];
      prev_wv[k] = v[k];
    end
  end

  // Expected window n of a frame whose pixel (row,col) carries base + row*NC + col.
  function automatic logic [WB-1:0] exp_win(input int base, input int s, input int n);
    logic [WB-1:0] w;
    int per, tr, tc;
    w   = '0;
    per = (NC - K) / s + 1;
    tr  = n / per;
    tc  = n % per;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'(base + (tr*s + r)*NC + tc*s + c);
    return w;
  endfunction

  function automatic logic [WB-1:0] pack9(input int v [9]);
    logic [WB-1:0] w;
    for (int i = 0; i < KK; i++) w[i*DW +: DW] = DW'(v[i]);
    return w;
  endfunction

  task automatic send(input int idx, input int px, input bit gaps);
    int budget;
    logic rdy;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        if (idx == 0) pv_a = 1'b0; else pv_b = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (idx == 0) begin pixel_a = DW'(px); pv_a = 1'b1; end
    else begin pixel_b = DW'(px); pv_b = 1'b1; end
    budget = 0;
    forever begin
      @(negedge clk);
      rdy = (idx == 0) ? ready_a : ready_b;
      if (rdy === 1'b1) begin
        @(posedge clk); #1;
        break;
      end
      budget++;
      if (budget > 300) begin
        comps++; errs++;
        $display("FAIL send_timeout dut%0d pixel %0d got no ready within 300 cycles", idx, px);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int idx);
    logic v, h, r;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      v = (idx == 0) ? wv_a : wv_b;
      h = (idx == 0) ? hold_a : hold_b;
      r = (idx == 0) ? ready_a : ready_b;
      if (v === 1'b0 && h === 1'b0 && r === 1'b1) done = 1'b1;
    end
    if (!done) begin
      comps++; errs++;
      $display("FAIL idle_timeout dut%0d valid=%b ready=%b required idle", idx, v, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int idx, input int base, input bit gaps);
    for (int i = 0; i < 25; i++) send(idx, base + i, gaps);
    if (idx == 0) pv_a = 1'b0; else pv_b = 1'b0;
    wait_idle(idx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    comps++; if (wv_a !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", wv_a); end
    comps++; if (fd_a !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", fd_a); end
    comps++; if (ready_a !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", ready_a); end
    comps++; if (wflat_a !== '0) begin errs++; $display("FAIL reset_window got %h want 0", wflat_a); end
    comps++; if (ready_b !== 1'b1 || wv_b !== 1'b0) begin
      errs++; $display("FAIL reset_b got ready=%b valid=%b want 1/0", ready_b, wv_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  // Checks a stride-1 frame (or frames) of dut_a against the window model.
  task automatic check_frames_a(input string tag, input int w0, input int f0,
                                input int q0, input int e0, input int nframes);
    int cnt, bad;
    cnt = cap_q0.size() - w0;
    comps++; if (cnt !== 9*nframes) begin errs++; $display("FAIL %s_count got %0d want %0d", tag, cnt, 9*nframes); end
    for (int n = 0; n < 9*nframes && w0 + n < cap_q0.size(); n++) begin
      comps++;
      if (cap_q0[w0+n] !== exp_win(25*(n/9), 1, n%9)) begin
        errs++; $display("FAIL %s_win%0d got %h want %h", tag, n, cap_q0[w0+n], exp_win(25*(n/9), 1, n%9));
      end
      $display("%s: window %0d top-left %0d", tag, n, cap_q0[w0+n][DW-1:0]);
    end
    comps++; if (fd_cnt[0] - f0 !== nframes) begin
      errs++; $display("FAIL %s_frame_done got %0d pulses want %0d", tag, fd_cnt[0] - f0, nframes);
    end
    comps++; if (fd_at[0] !== w0 + 9*nframes) begin
      errs++; $display("FAIL %s_done_pos got after window %0d want %0d", tag, fd_at[0] - w0, 9*nframes);
    end
    bad = 0;
    if (xq0.size() - q0 != 25*nframes) bad = 1;
    else for (int i = 0; i < 25*nframes; i++) if (xq0[q0+i] != i) bad = 1;
    comps++; if (bad !== 0) begin errs++; $display("FAIL %s_scoreboard got %0d transfers want %0d in order", tag, xq0.size() - q0, 25*nframes); end
    comps++; if (stab_err[0] - e0 !== 0) begin
      errs++; $display("FAIL %s_stable got %0d violations want 0", tag, stab_err[0] - e0);
    end
  endtask

  task automatic test_stride1();
    int w0, f0, x0, q0, e0;
    int first_exp [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int last_exp  [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    w0 = cap_q0.size(); f0 = fd_cnt[0]; x0 = xfer_cnt[0]; q0 = xq0.size(); e0 = stab_err[0];
    hold_len_a = 3; hold_rand_a = 1'b0;
    run_frame(0, 0, 1'b0);
    check_frames_a("stride1", w0, f0, q0, e0, 1);
    if (cap_q0.size() >= w0 + 9) begin
      comps++; if (cap_q0[w0] !== pack9(first_exp)) begin errs++; $display("FAIL stride1_first got %h want %h", cap_q0[w0], pack9(first_exp)); end
      comps++; if (cap_q0[w0+8] !== pack9(last_exp)) begin errs++; $display("FAIL stride1_last got %h want %h", cap_q0[w0+8], pack9(last_exp)); end
      comps++; if (rq0[w0] - x0 !== 13) begin errs++; $display("FAIL stride1_latency got %0d transfers at valid want 13", rq0[w0] - x0); end
    end
    comps++; if (last_run[0] !== 5) begin errs++; $display("FAIL stride1_valid_len got %0d cycles want 5", last_run[0]); end
  endtask

  task automatic test_stride2();
    int w0, f0, e0, cnt;
    int second_exp [9] = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
    w0 = cap_q1.size(); f0 = fd_cnt[1]; e0 = stab_err[1];
    hold_len_b = 3;
    run_frame(1, 0, 1'b0);
    cnt = cap_q1.size() - w0;
    comps++; if (cnt !== 4) begin errs++; $display("FAIL stride2_count got %0d want 4", cnt); end
    for (int n = 0; n < 4 && w0 + n < cap_q1.size(); n++) begin
      comps++;
      if (cap_q1[w0+n] !== exp_win(0, 2, n)) begin
        errs++; $display("FAIL stride2_win%0d got %h want %h", n, cap_q1[w0+n], exp_win(0, 2, n));
      end
      $display("stride2: window %0d top-left %0d", n, cap_q1[w0+n][DW-1:0]);
    end
    if (cnt >= 2) begin
      comps++; if (cap_q1[w0+1] !== pack9(second_exp)) begin errs++; $display("FAIL stride2_second got %h want %h", cap_q1[w0+1], pack9(second_exp)); end
    end
    comps++; if (fd_cnt[1] - f0 !== 1 || fd_at[1] !== w0 + 4) begin
      errs++; $display("FAIL stride2_frame_done got %0d pulses at window %0d want 1 at 4", fd_cnt[1] - f0, fd_at[1] - w0);
    end
    comps++; if (stab_err[1] - e0 !== 0) begin errs++; $display("FAIL stride2_stable got %0d want 0", stab_err[1] - e0); end
  endtask

  task automatic test_long_hold();
    int w0, f0, q0, e0;
    w0 = cap_q0.size(); f0 = fd_cnt[0]; q0 = xq0.size(); e0 = stab_err[0];
    hold_len_a = 20;
    run_frame(0, 0, 1'b0);
    check_frames_a("long_hold", w0, f0, q0, e0, 1);
    comps++; if (last_run[0] !== 22) begin errs++; $display("FAIL long_hold_valid_len got %0d cycles want 22", last_run[0]); end
    hold_len_a = 3;
  endtask

  task automatic test_mid_reset();
    int w0, f0, q0, e0;
    hold_len_a = 3;
    for (int i = 0; i < 8; i++) send(0, i, 1'b0);
    pv_a = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    comps++; if (wv_a !== 1'b0) begin errs++; $display("FAIL midreset_valid got %b want 0", wv_a); end
    comps++; if (fd_a !== 1'b0) begin errs++; $display("FAIL midreset_done got %b want 0", fd_a); end
    comps++; if (ready_a !== 1'b1) begin errs++; $display("FAIL midreset_ready got %b want 1", ready_a); end
    @(posedge clk); #1;
    w0 = cap_q0.size(); f0 = fd_cnt[0]; q0 = xq0.size(); e0 = stab_err[0];
    run_frame(0, 0, 1'b0);
    check_frames_a("midreset", w0, f0, q0, e0, 1);
  endtask

  task automatic test_random_gaps();
    int w0, f0, q0, e0;
    w0 = cap_q0.size(); f0 = fd_cnt[0]; q0 = xq0.size(); e0 = stab_err[0];
    hold_rand_a = 1'b1;
    for (int i = 0; i < 50; i++) send(0, i, 1'b1);
    pv_a = 1'b0;
    wait_idle(0);
    hold_rand_a = 1'b0;
    check_frames_a("random", w0, f0, q0, e0, 2);
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_long_hold();
    test_mid_reset();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

  // Absolute time limit so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("FAIL global_timeout got no completion want finish before limit");
    errs++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $fatal(1, "timeout");
  end

endmodule
